// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises MIPS instruction-fetch and load/store requests onto a
// single request/ready memory bus.
//
// Ports
//   i_clk, i_rst           : clock (rising edge) and synchronous active-high reset
//   i_inst_*, o_inst_*     : fetch port; request held until o_inst_valid pulse
//   i_data_*, o_data_*     : load/store port; i_data_wen == 0 means read
//   o_bus_err              : qualifies a valid pulse whose transaction timed out
//   o_stall                : pipeline stall while any request is outstanding
//   o_mem_*, i_mem_*       : shared memory bus; i_mem_ready is a one-cycle completion
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inst_req,
  input  logic [31:0] i_inst_addr,
  output logic [31:0] o_inst_rdata,
  output logic        o_inst_valid,
  input  logic        i_data_req,
  input  logic [3:0]  i_data_wen,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic [31:0] o_data_rdata,
  output logic        o_data_valid,
  output logic        o_bus_err,
  output logic        o_stall,
  output logic        o_mem_req,
  output logic [3:0]  o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready
);

  localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD, StDone} state_e;

  state_e      r_state;
  logic [7:0]  r_cnt;
  logic        r_last_data;  // 1: data port was granted most recently
  logic        r_mem_req;
  logic [3:0]  r_mem_wen;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;
  logic        r_inst_valid;
  logic        r_data_valid;
  logic        r_bus_err;

  logic        w_pick_data;
  logic        w_pick_inst;
  logic        w_timeout;
  logic [31:0] w_done_rdata;

  // Under contention the port that was not served last wins.
  assign w_pick_data  = i_data_req & (~i_inst_req | ~r_last_data);
  assign w_pick_inst  = i_inst_req & ~w_pick_data;
  assign w_timeout    = (r_cnt == LastCnt);
  // Ready wins over a coincident timeout; an aborted transaction returns zero.
  assign w_done_rdata = i_mem_ready ? i_mem_rdata : 32'h0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_cnt        <= 8'h0;
      r_last_data  <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_wen    <= 4'h0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_inst_rdata <= 32'h0;
      r_data_rdata <= 32'h0;
      r_inst_valid <= 1'b0;
      r_data_valid <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses asserted only in StDone.
      r_inst_valid <= 1'b0;
      r_data_valid <= 1'b0;
      r_bus_err    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_pick_data) begin
            r_state     <= StGntD;
            r_mem_req   <= 1'b1;
            r_mem_wen   <= i_data_wen;
            r_mem_addr  <= i_data_addr;
            r_mem_wdata <= i_data_wdata;
            r_cnt       <= 8'h0;
            r_last_data <= 1'b1;
          end else if (w_pick_inst) begin
            r_state     <= StGntI;
            r_mem_req   <= 1'b1;
            r_mem_wen   <= 4'h0;
            r_mem_addr  <= i_inst_addr;
            r_mem_wdata <= 32'h0;
            r_cnt       <= 8'h0;
            r_last_data <= 1'b0;
          end
        end
        StGntI, StGntD: begin
          if (i_mem_ready || w_timeout) begin
            r_state   <= StDone;
            r_mem_req <= 1'b0;
            r_bus_err <= ~i_mem_ready;
            if (r_state == StGntD) begin
              r_data_valid <= 1'b1;
              r_data_rdata <= w_done_rdata;
            end else begin
              r_inst_valid <= 1'b1;
              r_inst_rdata <= w_done_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_stall      = (i_inst_req & ~r_inst_valid) | (i_data_req & ~r_data_valid);
  assign o_mem_req    = r_mem_req;
  assign o_mem_wen    = r_mem_wen;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_inst_rdata = r_inst_rdata;
  assign o_inst_valid = r_inst_valid;
  assign o_data_rdata = r_data_rdata;
  assign o_data_valid = r_data_valid;
  assign o_bus_err    = r_bus_err;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter between the MIPS core and a single shared memory bus. It takes instruction-fetch requests from the fetch stage and load/store requests from the memory stage (after byte-lane selection, i.e. `memwrite`/`writedata` already formatted), serialises them onto one request/ready memory interface, and returns read data and completion pulses to each port. It also drives a pipeline stall while any request is outstanding and flags bus timeouts as errors.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles to wait for `mem_ready` in a grant state before aborting; 8-bit counter, valid range 1–255.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_req`  in  1  fetch request; held high until `inst_valid`.
- `inst_addr`  in  32  fetch address (pcF).
- `inst_rdata`  out  32  fetched instruction; valid while `inst_valid`.
- `inst_valid`  out  1  one-cycle completion pulse, fetch port.
- `data_req`  in  1  load/store request (memenM); held high until `data_valid`.
- `data_wen`  in  4  byte write enables; 0 = read.
- `data_addr`  in  32  data address (aluoutM).
- `data_wdata`  in  32  lane-formatted store data.
- `data_rdata`  out  32  load data; valid while `data_valid`.
- `data_valid`  out  1  one-cycle completion pulse, data port.
- `bus_err`  out  1  with a valid pulse: the transaction timed out; rdata = 0.
- `stall`  out  1  `(inst_req & ~inst_valid) | (data_req & ~data_valid)`, combinational.
- `mem_req`  out  1  request to memory; held through a grant state.
- `mem_wen`  out  4  byte enables of granted transaction.
- `mem_addr`  out  32  address of granted transaction.
- `mem_wdata`  out  32  store data of granted transaction.
- `mem_rdata`  in  32  read data; sampled when `mem_ready`.
- `mem_ready`  in  1  one-cycle completion from memory.

## Operation
- States: IDLE, GNT_I, GNT_D, DONE.
- IDLE: requests sampled. Only `data_req` -> GNT_D. Only `inst_req` -> GNT_I. Both -> the port *not* granted last (`last_gnt`). Neither -> stay.
- On leaving IDLE: latch address, wen (forced 0 for GNT_I), and wdata into `mem_*` registers; clear the timeout counter; record the port in `last_gnt`.
- GNT_I/GNT_D: `mem_req`=1 and `mem_*` are stable. Each cycle without `mem_ready`, the counter increments.
  - `mem_ready`: latch `mem_rdata` into the granted port's rdata register and go to DONE with err=0.
  - Counter reaches `TIMEOUT-1` without ready: go to DONE with err=1 and rdata=0.
  - `mem_ready` takes precedence over timeout in the same cycle.
- DONE: `mem_req`=0. The granted port's valid=1, and `bus_err`=err. Requests are not sampled. Next state is IDLE unconditionally.
- Requester rules:
  - A requester must drop or replace its request in the cycle after its valid.
  - Request inputs may change only in that cycle; the arbiter uses latched copies.
- The rdata registers hold their value until the next completion on the same port.
- Reset:
  - State = IDLE.
  - `last_gnt` = INST, so the first conflict goes to data.
  - Counter, `mem_req`, `mem_wen`, `mem_addr`, `mem_wdata`, both rdata, both valids, and `bus_err` all = 0.
  - `stall` is combinational and follows the requests.
- Reset mid-transaction: the transaction is abandoned, no valid is issued, and `mem_req` drops the next cycle. A late `mem_ready` arriving in IDLE is ignored.

## Timing
- Request sampled in IDLE at cycle t:
  - `mem_req` goes high at t+1.
  - With `mem_ready` at t+1+k, the valid pulse is at t+2+k and IDLE is at t+3+k.
  - Minimum latency from request to valid is 2 cycles; minimum spacing between grants is 3 cycles.
- Timeout: valid with `bus_err` at t+1+TIMEOUT.
- Back-to-back conflict: after a data completion, a pending fetch is granted on the next IDLE, and vice versa (strict alternation under contention).
- `stall` is high in the same cycle a request rises and low in the valid cycle.

## Test plan
- Reset, then fetch only: `inst_req`=1, `inst_addr`=0xBFC00000, memory returns 0x3C081234 with `mem_ready` 1 cycle after `mem_req`.
  - Expect `mem_req` at t+1 with `mem_wen`=0, `inst_valid` at t+3, `inst_rdata`=0x3C081234, and `stall` high for cycles t..t+2.
- Store: `data_req`=1, `data_wen`=4'b0011, `data_addr`=0x80000010, `data_wdata`=0x0000ABCD.
  - Expect `mem_*` to carry these exact values and `data_valid` one cycle after `mem_ready`.
- Simultaneous requests after reset:
  - Expect data granted first, then inst.
  - Repeating the conflict alternates inst/data/inst.
- Memory never asserts ready with `TIMEOUT`=4:
  - Expect `data_valid`=1, `bus_err`=1, `data_rdata`=0 at t+5, then `mem_req`=0.
- `rst` asserted in GNT_D with `mem_ready` arriving the cycle after:
  - Expect no valid pulse, all outputs 0, and state IDLE.
- `mem_ready` coincident with the timeout cycle:
  - Expect `bus_err`=0 and `rdata`=`mem_rdata`.
